// File: rtl/traffic_pkg.sv
// traffic_pkg: shared encodings for the traffic light safety monitor.
//   - lamp encoding (one-hot red/yellow/green)
//   - monitor FSM state enum
//   - fault code constants, 0 = none, 1..9 in priority order (lowest wins)
//   - small helpers for lamp legality
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  typedef enum logic [1:0] {
    MON_INIT  = 2'd0,
    MON_RUN   = 2'd1,
    MON_FAULT = 2'd2
  } mon_state_t;

  localparam logic [3:0] FLT_NONE     = 4'd0;
  localparam logic [3:0] FLT_NS_ENC   = 4'd1;
  localparam logic [3:0] FLT_EW_ENC   = 4'd2;
  localparam logic [3:0] FLT_CONFLICT = 4'd3;
  localparam logic [3:0] FLT_PED      = 4'd4;
  localparam logic [3:0] FLT_NS_SEQ   = 4'd5;
  localparam logic [3:0] FLT_EW_SEQ   = 4'd6;
  localparam logic [3:0] FLT_NS_YEL   = 4'd7;
  localparam logic [3:0] FLT_EW_YEL   = 4'd8;
  localparam logic [3:0] FLT_GREEN_TO = 4'd9;

  function automatic logic is_onehot3(input logic [2:0] l);
    return (l == LIGHT_RED) || (l == LIGHT_YEL) || (l == LIGHT_GRN);
  endfunction

  // red -> green -> yellow -> red, holding the same lamp is always legal
  function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
    return (cur == prev) ||
           ((prev == LIGHT_RED) && (cur == LIGHT_GRN)) ||
           ((prev == LIGHT_GRN) && (cur == LIGHT_YEL)) ||
           ((prev == LIGHT_YEL) && (cur == LIGHT_RED));
  endfunction

endpackage

// File: rtl/traffic_conflict_monitor_light_seq_checker.sv
// light_seq_checker: per-direction lamp sequence checker.
//   Tracks the previous lamp state and the consecutive yellow/green run
//   lengths, and flags encoding, transition, short-yellow and green-timeout
//   problems for the current registered sample.
// Ports:
//   clk        system clock
//   clr        synchronous clear: previous lamp -> red, counters -> 0
//   en         a valid sample is present this cycle
//   light      registered lamp sample (one-hot r/y/g)
//   enc_err    sample is not one-hot
//   trans_err  prev -> light is not an allowed step
//   short_yel  yellow -> red after fewer than MIN_YELLOW yellow samples
//   green_to   this sample completes MAX_GREEN consecutive greens
module light_seq_checker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_GREEN  = 64
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic [2:0] light,
  output logic       enc_err,
  output logic       trans_err,
  output logic       short_yel,
  output logic       green_to
);

  localparam int CW = $clog2(MAX_GREEN + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] MIN_Y   = CW'(MIN_YELLOW);
  localparam logic [CW:0]   MAX_G   = (CW+1)'(MAX_GREEN);

  logic [2:0]    prev;
  logic [CW-1:0] yel_cnt;   // yellow samples ending at prev
  logic [CW-1:0] grn_cnt;   // green samples ending at prev
  logic [CW:0]   grn_run;   // green run length including this sample

  always_comb begin
    grn_run   = (prev == LIGHT_GRN) ? ({1'b0, grn_cnt} + (CW+1)'(1)) : (CW+1)'(1);
    enc_err   = !is_onehot3(light);
    // only judge steps between two well-formed lamps; encoding has its own code
    trans_err = is_onehot3(light) && is_onehot3(prev) && !legal_step(prev, light);
    short_yel = (prev == LIGHT_YEL) && (light == LIGHT_RED) && (yel_cnt < MIN_Y);
    green_to  = (light == LIGHT_GRN) && (grn_run >= MAX_G);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      prev    <= LIGHT_RED;
      yel_cnt <= '0;
      grn_cnt <= '0;
    end else if (en) begin
      prev <= light;
      if (light == LIGHT_YEL)
        yel_cnt <= (prev != LIGHT_YEL) ? CNT_ONE :
                   (yel_cnt == CNT_MAX) ? yel_cnt : yel_cnt + CNT_ONE;
      else
        yel_cnt <= '0;
      if (light == LIGHT_GRN)
        grn_cnt <= (prev != LIGHT_GRN) ? CNT_ONE :
                   (grn_cnt == CNT_MAX) ? grn_cnt : grn_cnt + CNT_ONE;
      else
        grn_cnt <= '0;
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: independent safety monitor on the lamp outputs
// of the traffic light controller. Samples both directions and the WALK
// signal every cycle, latches the first fault (lowest code on ties) and
// requests flashing red. Purely observational.
//
// Optional build macro TRAFFIC_MON_FAULT_COUNT_EN adds fault_count[7:0],
// a saturating count of sample cycles with any active violation (cleared
// only by reset).
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   ns_light    NS lamps, one-hot {red,yellow,green}
//   ew_light    EW lamps, same encoding
//   ped_signal  pedestrian WALK
//   fault_clr   single-cycle request to clear a latched fault
//   fault       sticky fault flag
//   fault_code  first fault code, frozen while fault=1
//   flash_red   fail-safe flashing-red drive
//   mon_active  high while sequence checks are armed (MON_RUN)
//   fault_count (macro only) saturating violation-cycle count
//
// Latency: a sample applied before edge N is registered at N and judged at
// N+1, so faults show two cycles after the offending input. fault_clr is
// registered alongside the lamps so a clear is judged against the same
// sample it arrived with.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_GREEN  = 64,
  parameter int FLASH_HALF = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ns_light,
  input  logic [2:0] ew_light,
  input  logic       ped_signal,
  input  logic       fault_clr,
  output logic       fault,
  output logic [3:0] fault_code,
  output logic       flash_red,
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
  output logic [7:0] fault_count,
`endif
  output logic       mon_active
);

  localparam int NS = 0;
  localparam int EW = 1;
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

  // input sample stage
  logic [1:0][2:0] lamp_r;
  logic            ped_r;
  logic            clr_r;
  logic            samp_vld;   // low for the first cycle after reset

  always_ff @(posedge clk) begin
    if (reset) begin
      lamp_r   <= {LIGHT_RED, LIGHT_RED};
      ped_r    <= 1'b0;
      clr_r    <= 1'b0;
      samp_vld <= 1'b0;
    end else begin
      lamp_r   <= {ew_light, ns_light};
      ped_r    <= ped_signal;
      clr_r    <= fault_clr;
      samp_vld <= 1'b1;
    end
  end

  // per-direction sequence checkers
  logic [1:0] enc_err, trans_err, short_yel, green_to;
  logic       chk_clr;
  logic       clear_go;

  assign chk_clr = reset || clear_go;

  for (genvar d = 0; d < 2; d++) begin : g_dir
    light_seq_checker #(
      .MIN_YELLOW (MIN_YELLOW),
      .MAX_GREEN  (MAX_GREEN)
    ) u_chk (
      .clk       (clk),
      .clr       (chk_clr),
      .en        (samp_vld),
      .light     (lamp_r[d]),
      .enc_err   (enc_err[d]),
      .trans_err (trans_err[d]),
      .short_yel (short_yel[d]),
      .green_to  (green_to[d])
    );
  end

  // priority encoding
  mon_state_t state;
  logic [3:0] aa_code;    // always-armed checks
  logic [3:0] seq_code;   // sequence checks, armed only in RUN
  logic [3:0] cur_code;
  logic       viol;

  always_comb begin
    aa_code = FLT_NONE;
    if (enc_err[NS])
      aa_code = FLT_NS_ENC;
    else if (enc_err[EW])
      aa_code = FLT_EW_ENC;
    else if ((lamp_r[NS] != LIGHT_RED) && (lamp_r[EW] != LIGHT_RED))
      aa_code = FLT_CONFLICT;
    else if (ped_r && ((lamp_r[NS] != LIGHT_RED) || (lamp_r[EW] != LIGHT_RED)))
      aa_code = FLT_PED;

    seq_code = FLT_NONE;
    if (trans_err[NS])
      seq_code = FLT_NS_SEQ;
    else if (trans_err[EW])
      seq_code = FLT_EW_SEQ;
    else if (short_yel[NS])
      seq_code = FLT_NS_YEL;
    else if (short_yel[EW])
      seq_code = FLT_EW_YEL;
    else if (|green_to)
      seq_code = FLT_GREEN_TO;

    // in INIT and FAULT only the always-armed checks count as violations
    cur_code = (aa_code != FLT_NONE)  ? aa_code  :
               (state == MON_RUN)     ? seq_code : FLT_NONE;
    viol     = samp_vld && (cur_code != FLT_NONE);
    // a clear that coincides with a violating sample is refused
    clear_go = samp_vld && (state == MON_FAULT) && clr_r && !viol;
  end

  // monitor FSM with registered outputs
  logic [FW-1:0] flash_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= MON_INIT;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
      flash_red  <= 1'b0;
      mon_active <= 1'b0;
      flash_cnt  <= '0;
    end else if (samp_vld) begin
      case (state)
        MON_INIT, MON_RUN: begin
          if (viol) begin
            state      <= MON_FAULT;
            fault      <= 1'b1;
            fault_code <= cur_code;
            flash_red  <= 1'b1;
            mon_active <= 1'b0;
            flash_cnt  <= '0;
          end else if ((state == MON_INIT) &&
                       (lamp_r[NS] == LIGHT_RED) && (lamp_r[EW] == LIGHT_RED)) begin
            state      <= MON_RUN;
            mon_active <= 1'b1;
          end
        end
        MON_FAULT: begin
          if (clear_go) begin
            state      <= MON_INIT;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
            flash_red  <= 1'b0;
            flash_cnt  <= '0;
          end else if (flash_cnt == FLASH_LAST) begin
            flash_red <= ~flash_red;
            flash_cnt <= '0;
          end else begin
            flash_cnt <= flash_cnt + FW'(1);
          end
        end
        default: state <= MON_INIT;
      endcase
    end
  end

`ifdef TRAFFIC_MON_FAULT_COUNT_EN
  logic [7:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      fcnt_q <= 8'd0;
    else if (viol && (fcnt_q != 8'hFF))
      fcnt_q <= fcnt_q + 8'd1;
  end

  assign fault_count = fcnt_q;
`endif

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor. Each driven sample is run
// through a behavioural model (lamp history + run lengths counted from the
// history) and its expected outputs are queued, tagged with the clock edge
// at which they must appear. A monitor process compares on every edge.
module tb_traffic_conflict_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] ns_light = R;
  logic [2:0] ew_light = R;
  logic       ped_signal = 1'b0;
  logic       fault_clr = 1'b0;
  logic       fault;
  logic [3:0] fault_code;
  logic       flash_red;
  logic       mon_active;
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
  logic [7:0] fault_count;
`endif

  always #5 clk = ~clk;

  traffic_conflict_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .ped_signal (ped_signal),
    .fault_clr  (fault_clr),
    .fault      (fault),
    .fault_code (fault_code),
    .flash_red  (flash_red),
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
    .fault_count(fault_count),
`endif
    .mon_active (mon_active)
  );

  typedef struct {
    int         tag;
    logic       f;
    logic [3:0] code;
    logic       fl;
    logic       ma;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int pe    = 0;   // posedge counter, advanced just after each edge

  // ---------------- reference model ----------------
  int         m_mode;   // 0 init, 1 run, 2 fault
  logic       m_fault;
  logic [3:0] m_code;
  int         m_age;    // cycles spent in fault
  logic       m_ma;
  int         m_cnt;
  logic [2:0] hn[$];
  logic [2:0] he[$];

  function automatic logic oh(input logic [2:0] l);
    return (l == R) || (l == Y) || (l == G);
  endfunction

  // position in the red -> green -> yellow ring
  function automatic int pos(input logic [2:0] l);
    return (l == R) ? 0 : (l == G) ? 1 : 2;
  endfunction

  function automatic logic bad_step(input logic [2:0] p, input logic [2:0] c);
    return oh(p) && oh(c) && (p != c) && (pos(c) != (pos(p) + 1) % 3);
  endfunction

  function automatic int trail(input logic [2:0] h[$], input logic [2:0] v);
    int k = 0;
    for (int i = h.size() - 1; i >= 0; i--) begin
      if (h[i] != v) break;
      k++;
    end
    return k;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fault = 0; m_code = 0; m_age = 0; m_ma = 0; m_cnt = 0;
    hn.delete(); he.delete();
    hn.push_back(R); he.push_back(R);
  endtask

  task automatic model_step(input logic [2:0] n, input logic [2:0] e,
                            input logic p, input logic c);
    int aa, sq, cd;
    logic [2:0] pn, pw;
    logic cleared;
    aa = 0;
    if (!oh(n)) aa = 1;
    else if (!oh(e)) aa = 2;
    else if (n != R && e != R) aa = 3;
    else if (p && (n != R || e != R)) aa = 4;
    pn = hn[hn.size()-1];
    pw = he[he.size()-1];
    sq = 0;
    if (bad_step(pn, n)) sq = 5;
    else if (bad_step(pw, e)) sq = 6;
    else if (pn == Y && n == R && trail(hn, Y) < 3) sq = 7;
    else if (pw == Y && e == R && trail(he, Y) < 3) sq = 8;
    else if ((n == G && trail(hn, G) + 1 >= 64) || (e == G && trail(he, G) + 1 >= 64)) sq = 9;
    cd = (aa != 0) ? aa : ((m_mode == 1) ? sq : 0);
    if (cd != 0 && m_cnt < 255) m_cnt++;
    cleared = 0;
    if (m_mode == 2) begin
      if (c && cd == 0) begin
        m_mode = 0; m_fault = 0; m_code = 0; m_age = 0; cleared = 1;
      end else m_age++;
    end else if (cd != 0) begin
      m_mode = 2; m_fault = 1; m_code = 4'(cd); m_age = 0; m_ma = 0;
    end else if (m_mode == 0 && n == R && e == R) begin
      m_mode = 1; m_ma = 1;
    end
    if (cleared) begin
      hn.delete(); he.delete(); hn.push_back(R); he.push_back(R);
    end else begin
      hn.push_back(n); he.push_back(e);
      if (hn.size() > 200) begin void'(hn.pop_front()); void'(he.pop_front()); end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [2:0] n, input logic [2:0] e,
                       input logic p, input logic c);
    exp_t x;
    @(negedge clk);
    reset = 0; ns_light = n; ew_light = e; ped_signal = p; fault_clr = c;
    model_step(n, e, p, c);
    x.tag = pe + 2; x.f = m_fault; x.code = m_code;
    x.fl = (m_mode == 2) && ((m_age / 8) % 2 == 0);
    x.ma = m_ma; x.cnt = m_cnt;
    q.push_back(x);
  endtask

  task automatic do_reset();
    exp_t x;
    @(negedge clk);
    reset = 1; ns_light = R; ew_light = R; ped_signal = 0; fault_clr = 0;
    model_reset();
    while (q.size() > 0 && q[q.size()-1].tag >= pe + 1) void'(q.pop_back());
    x.tag = pe + 1; x.f = 0; x.code = 0; x.fl = 0; x.ma = 0; x.cnt = 0;
    q.push_back(x);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #1;
    pe++;
    while (q.size() > 0 && q[0].tag < pe) void'(q.pop_front());
    if (q.size() > 0 && q[0].tag == pe) begin
      exp_t x;
      x = q.pop_front();
      chk($sformatf("sb_fault@%0d", pe), int'(fault), int'(x.f));
      chk($sformatf("sb_code@%0d", pe), int'(fault_code), int'(x.code));
      chk($sformatf("sb_flash@%0d", pe), int'(flash_red), int'(x.fl));
      chk($sformatf("sb_active@%0d", pe), int'(mon_active), int'(x.ma));
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
      chk($sformatf("sb_count@%0d", pe), int'(fault_count), x.cnt);
`endif
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [2:0] n, e;
    logic p, c;
    int phase, left;

    model_reset();
    do_reset();
    drive(R, R, 0, 0);
    chk("reset_fault", int'(fault), 0);
    chk("reset_code", int'(fault_code), 0);
    chk("reset_flash", int'(flash_red), 0);
    chk("reset_active", int'(mon_active), 0);

    // normal cycle
    drive(R, R, 0, 0);
    repeat (10) drive(G, R, 0, 0);
    repeat (3)  drive(Y, R, 0, 0);
    drive(R, R, 0, 0);
    repeat (10) drive(R, G, 0, 0);
    repeat (3)  drive(R, Y, 0, 0);
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    chk("normal_fault", int'(fault), 0);
    chk("normal_active", int'(mon_active), 1);

    // conflict and flash cadence
    drive(G, G, 0, 0);
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    chk("conflict_code", int'(fault_code), 3);
    chk("conflict_flash_on", int'(flash_red), 1);
    repeat (8) drive(R, R, 0, 0);
    chk("flash_off", int'(flash_red), 0);
    repeat (8) drive(R, R, 0, 0);
    chk("flash_on_again", int'(flash_red), 1);

    // short yellow
    drive(R, R, 0, 1);
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    drive(G, R, 0, 0);
    drive(Y, R, 0, 0);
    drive(Y, R, 0, 0);
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    chk("short_yellow_code", int'(fault_code), 7);

    // skipped yellow
    drive(R, R, 0, 1);
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    drive(G, R, 0, 0);
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    chk("skip_yellow_code", int'(fault_code), 5);

    // encoding beats conflict and ped
    drive(R, R, 0, 1);
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    drive(3'b011, R, 1, 0);
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    chk("prio_enc_code", int'(fault_code), 1);

    // ped with NS green
    do_reset();
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    drive(G, R, 1, 0);
    drive(G, R, 0, 0);
    drive(G, R, 0, 0);
    chk("ped_code", int'(fault_code), 4);

    // green watchdog
    do_reset();
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    repeat (63) drive(G, R, 0, 0);
    drive(G, R, 0, 0);
    chk("green_63_no_fault", int'(fault), 0);
    drive(Y, R, 0, 0);
    drive(Y, R, 0, 0);
    chk("green_to_code", int'(fault_code), 9);

    // clear refused while EW lamps are dark
    drive(R, 3'b000, 0, 1);
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    chk("clear_race_fault", int'(fault), 1);
    chk("clear_race_code", int'(fault_code), 9);
    // clean clear
    drive(R, R, 0, 1);
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    chk("clear_fault", int'(fault), 0);
    chk("clear_code", int'(fault_code), 0);
    chk("clear_flash", int'(flash_red), 0);

    // reset in fault
    drive(G, G, 0, 0);
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    do_reset();
    drive(R, R, 0, 0);
    chk("midreset_fault", int'(fault), 0);
    chk("midreset_flash", int'(flash_red), 0);

`ifdef TRAFFIC_MON_FAULT_COUNT_EN
    drive(R, R, 0, 0);
    repeat (5) drive(G, G, 0, 0);
    drive(R, R, 0, 1);
    drive(R, R, 0, 0);
    drive(R, R, 0, 0);
    chk("count_five", int'(fault_count), 5);
    chk("count_clear_fault", int'(fault), 0);
`endif

    // randomized traffic with injected faults
    phase = 0; left = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
        phase = 0; left = 0;
      end
      if (left == 0) begin
        phase = (phase + 1) % 6;
        case (phase)
          0, 3:    left = $urandom_range(1, 3);
          1, 4:    left = $urandom_range(1, 70);
          default: left = $urandom_range(1, 5);
        endcase
      end
      left--;
      n = (phase == 1) ? G : (phase == 2) ? Y : R;
      e = (phase == 4) ? G : (phase == 5) ? Y : R;
      p = (phase == 0 || phase == 3) && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) < 2) n = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 2) e = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 2) p = 1'b1;
      c = ($urandom_range(0, 9) == 0);
      drive(n, e, p, c);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
